// File: rtl/eth_pkt_demux_ctrl.sv
// Packet-boundary-safe direction scheduler for the Ethernet demux: config shadowing, round-robin steering, stats.
// Latency: outputs registered; a config write on an idle link reaches tx_dir_mask_o two cycles later.
// Backpressure: passive tap of the demux handshake; only val&&ready beats count, never stalls the link.
module eth_pkt_demux_ctrl #(
    parameter int                TX_DIR   = 2,
    parameter int                CNT_W    = 32,
    parameter logic [TX_DIR-1:0] RST_MASK = '1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [TX_DIR-1:0] cfg_mask_i,
    input  logic              cfg_mode_i,
    input  logic              cfg_wr_i,
    output logic              cfg_busy_o,
    output logic              cfg_applied_o,
    input  logic              cnt_clr_i,
    input  logic              pkt_val_i,
    input  logic              pkt_ready_i,
    input  logic              pkt_sop_i,
    input  logic              pkt_eop_i,
    output logic [TX_DIR-1:0] tx_dir_mask_o,
    output logic              in_pkt_o,
    output logic [CNT_W-1:0]  pkt_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int PTR_W = $clog2(TX_DIR);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            state, state_nxt;
    logic [TX_DIR-1:0] shadow_mask, act_mask, act_mask_nxt, onehot, mask_nxt;
    logic              shadow_mode, act_mode, act_mode_nxt, pending;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic              beat, sop_beat, eop_beat, update, apply;

    function automatic logic [PTR_W-1:0] lowest_bit(input logic [TX_DIR-1:0] m);
        lowest_bit = '0;
        for (int i = TX_DIR - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = PTR_W'(i);
        end
    endfunction

    // Circular search upward from p; descending loop so the nearest set bit wins.
    function automatic logic [PTR_W-1:0] next_bit(input logic [TX_DIR-1:0] m,
                                                  input logic [PTR_W-1:0]  p);
        int j;
        next_bit = p;
        for (int i = TX_DIR - 1; i >= 1; i--) begin
            j = int'(p) + i;
            if (j >= TX_DIR) j = j - TX_DIR;
            if (m[j]) next_bit = PTR_W'(j);
        end
    endfunction

    always_comb begin
        beat     = pkt_val_i & pkt_ready_i;
        sop_beat = beat & pkt_sop_i;
        eop_beat = beat & pkt_eop_i;

        state_nxt = state;
        case (state)
            IDLE:    if (sop_beat && !pkt_eop_i) state_nxt = IN_PKT;
            IN_PKT:  if (eop_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Any edge that leaves the FSM idle is a packet boundary.
        update = (state_nxt == IDLE);
        apply  = update & pending;

        act_mask_nxt = apply ? shadow_mask : act_mask;
        act_mode_nxt = apply ? shadow_mode : act_mode;

        if (apply)         ptr_nxt = lowest_bit(shadow_mask);
        else if (eop_beat) ptr_nxt = next_bit(act_mask, ptr);
        else               ptr_nxt = ptr;

        onehot          = '0;
        onehot[ptr_nxt] = 1'b1;
        mask_nxt        = act_mode_nxt ? (onehot & act_mask_nxt) : act_mask_nxt;
    end

    assign cfg_busy_o = pending;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            in_pkt_o      <= 1'b0;
            shadow_mask   <= RST_MASK;
            shadow_mode   <= 1'b0;
            pending       <= 1'b0;
            act_mask      <= RST_MASK;
            act_mode      <= 1'b0;
            ptr           <= '0;
            tx_dir_mask_o <= RST_MASK;
            cfg_applied_o <= 1'b0;
            pkt_cnt_o     <= '0;
            drop_cnt_o    <= '0;
        end else begin
            state    <= state_nxt;
            in_pkt_o <= (state_nxt == IN_PKT);

            if (cfg_wr_i) begin
                shadow_mask <= cfg_mask_i;
                shadow_mode <= cfg_mode_i;
            end
            // A write on the apply edge keeps pending set for the newly captured value.
            pending <= cfg_wr_i | (pending & ~apply);

            act_mask      <= act_mask_nxt;
            act_mode      <= act_mode_nxt;
            ptr           <= ptr_nxt;
            cfg_applied_o <= apply;
            if (update) tx_dir_mask_o <= mask_nxt;

            if (cnt_clr_i)                          pkt_cnt_o <= '0;
            else if (eop_beat && pkt_cnt_o != '1)   pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);

            if (cnt_clr_i)                          drop_cnt_o <= '0;
            else if (sop_beat && tx_dir_mask_o == '0 && drop_cnt_o != '1)
                                                    drop_cnt_o <= drop_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_eth_pkt_demux_ctrl.sv
// Directed bench: a 2-direction/32-bit-counter instance and a 4-direction/4-bit-counter instance share stimulus.
module tb_eth_pkt_demux_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_mask;
    logic       cfg_mode, cfg_wr, cnt_clr;
    logic       val, rdy, sop, eop;

    logic        busy2, appl2, inpkt2;
    logic [1:0]  mask2;
    logic [31:0] pc2, dc2;
    logic        busy4, appl4, inpkt4;
    logic [3:0]  mask4;
    logic [3:0]  pc4, dc4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eth_pkt_demux_ctrl #(.TX_DIR(2), .CNT_W(32), .RST_MASK(2'b11)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_mask_i(cfg_mask[1:0]), .cfg_mode_i(cfg_mode),
        .cfg_wr_i(cfg_wr), .cfg_busy_o(busy2), .cfg_applied_o(appl2), .cnt_clr_i(cnt_clr),
        .pkt_val_i(val), .pkt_ready_i(rdy), .pkt_sop_i(sop), .pkt_eop_i(eop),
        .tx_dir_mask_o(mask2), .in_pkt_o(inpkt2), .pkt_cnt_o(pc2), .drop_cnt_o(dc2));

    eth_pkt_demux_ctrl #(.TX_DIR(4), .CNT_W(4), .RST_MASK(4'b1111)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_mask_i(cfg_mask), .cfg_mode_i(cfg_mode),
        .cfg_wr_i(cfg_wr), .cfg_busy_o(busy4), .cfg_applied_o(appl4), .cnt_clr_i(cnt_clr),
        .pkt_val_i(val), .pkt_ready_i(rdy), .pkt_sop_i(sop), .pkt_eop_i(eop),
        .tx_dir_mask_o(mask4), .in_pkt_o(inpkt4), .pkt_cnt_o(pc4), .drop_cnt_o(dc4));

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_mask = 4'b0; cfg_mode = 1'b0; cfg_wr = 1'b0; cnt_clr = 1'b0;
        val = 1'b0; rdy = 1'b1; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic set_beat(input logic s, input logic e);
        val = 1'b1; rdy = 1'b1; sop = s; eop = e;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        step();
        n_chk++; if (mask2 !== 2'b11) begin n_fail++; $display("FAIL reset_mask2 got %b want 11", mask2); end
        n_chk++; if (mask4 !== 4'b1111) begin n_fail++; $display("FAIL reset_mask4 got %b want 1111", mask4); end
        n_chk++; if (busy2 !== 1'b0 || appl2 !== 1'b0 || inpkt2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got busy=%b appl=%b inpkt=%b want 0 0 0", busy2, appl2, inpkt2); end
        n_chk++; if (pc2 !== 32'd0 || dc2 !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got pkt=%0d drop=%0d want 0 0", pc2, dc2); end
    endtask

    task automatic test_idle_cfg();
        do_reset();
        cfg_mask = 4'b0001; cfg_mode = 1'b0; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        n_chk++; if (busy2 !== 1'b1 || mask2 !== 2'b11 || appl2 !== 1'b0) begin
            n_fail++; $display("FAIL idle_cfg_k1 got busy=%b mask=%b appl=%b want 1 11 0", busy2, mask2, appl2); end
        step();
        n_chk++; if (busy2 !== 1'b0 || mask2 !== 2'b01 || appl2 !== 1'b1) begin
            n_fail++; $display("FAIL idle_cfg_k2 got busy=%b mask=%b appl=%b want 0 01 1", busy2, mask2, appl2); end
        step();
        n_chk++; if (mask2 !== 2'b01 || appl2 !== 1'b0) begin
            n_fail++; $display("FAIL idle_cfg_k3 got mask=%b appl=%b want 01 0", mask2, appl2); end
    endtask

    task automatic test_mid_pkt();
        do_reset();
        set_beat(1'b1, 1'b0);
        step();
        n_chk++; if (inpkt2 !== 1'b1) begin n_fail++; $display("FAIL mid_inpkt got %b want 1", inpkt2); end
        set_beat(1'b0, 1'b0);
        cfg_mask = 4'b0010; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        n_chk++; if (busy2 !== 1'b1 || mask2 !== 2'b11) begin
            n_fail++; $display("FAIL mid_beat2 got busy=%b mask=%b want 1 11", busy2, mask2); end
        step();
        // Stalled eop (ready low) must not end the packet.
        set_beat(1'b0, 1'b1);
        rdy = 1'b0;
        step();
        n_chk++; if (inpkt2 !== 1'b1 || mask2 !== 2'b11 || appl2 !== 1'b0) begin
            n_fail++; $display("FAIL mid_stall got inpkt=%b mask=%b appl=%b want 1 11 0", inpkt2, mask2, appl2); end
        rdy = 1'b1;
        step();
        val = 1'b0; eop = 1'b0;
        n_chk++; if (mask2 !== 2'b10 || appl2 !== 1'b1 || inpkt2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL mid_after_eop got mask=%b appl=%b inpkt=%b busy=%b want 10 1 0 0",
                               mask2, appl2, inpkt2, busy2); end
        step();
        n_chk++; if (appl2 !== 1'b0 || pc2 !== 32'd1) begin
            n_fail++; $display("FAIL mid_tail got appl=%b pkt=%0d want 0 1", appl2, pc2); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp [6];
        exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        do_reset();
        cfg_mask = 4'b1011; cfg_mode = 1'b1; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        set_beat(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (mask4 !== exp[i]) begin
                n_fail++; $display("FAIL rr_pkt%0d got %b want %b", i, mask4, exp[i]); end
            step();
        end
        val = 1'b0;
        step();
        n_chk++; if (pc4 !== 4'd6 || inpkt4 !== 1'b0) begin
            n_fail++; $display("FAIL rr_count got pkt=%0d inpkt=%b want 6 0", pc4, inpkt4); end
    endtask

    task automatic test_drop();
        do_reset();
        cfg_mask = 4'b0000; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        n_chk++; if (mask2 !== 2'b00) begin n_fail++; $display("FAIL drop_mask got %b want 00", mask2); end
        set_beat(1'b1, 1'b1); step();
        set_beat(1'b1, 1'b0); step();
        set_beat(1'b0, 1'b1); step();
        set_beat(1'b1, 1'b1); step();
        val = 1'b0;
        step();
        n_chk++; if (dc2 !== 32'd3 || pc2 !== 32'd3) begin
            n_fail++; $display("FAIL drop_counts got drop=%0d pkt=%0d want 3 3", dc2, pc2); end
        set_beat(1'b1, 1'b1);
        cnt_clr = 1'b1;
        step();
        val = 1'b0; cnt_clr = 1'b0;
        n_chk++; if (dc2 !== 32'd0 || pc2 !== 32'd0) begin
            n_fail++; $display("FAIL drop_clear got drop=%0d pkt=%0d want 0 0", dc2, pc2); end
    endtask

    task automatic test_double_write();
        int pulses = 0;
        do_reset();
        set_beat(1'b1, 1'b0); step(); pulses += int'(appl2);
        set_beat(1'b0, 1'b0);
        cfg_mask = 4'b0001; cfg_wr = 1'b1; step(); pulses += int'(appl2);
        cfg_mask = 4'b0010; step(); pulses += int'(appl2);
        cfg_wr = 1'b0;
        n_chk++; if (busy2 !== 1'b1 || mask2 !== 2'b11) begin
            n_fail++; $display("FAIL dbl_pending got busy=%b mask=%b want 1 11", busy2, mask2); end
        set_beat(1'b0, 1'b1); step(); pulses += int'(appl2);
        val = 1'b0; eop = 1'b0;
        n_chk++; if (mask2 !== 2'b10) begin n_fail++; $display("FAIL dbl_mask got %b want 10", mask2); end
        for (int i = 0; i < 3; i++) begin step(); pulses += int'(appl2); end
        n_chk++; if (pulses != 1 || mask2 !== 2'b10) begin
            n_fail++; $display("FAIL dbl_pulses got pulses=%0d mask=%b want 1 10", pulses, mask2); end
    endtask

    task automatic test_reset_mid_pkt();
        do_reset();
        set_beat(1'b1, 1'b0); step();
        set_beat(1'b0, 1'b0);
        cfg_mask = 4'b0001; cfg_wr = 1'b1; step();
        idle_inputs();
        n_chk++; if (inpkt2 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got inpkt=%b busy=%b want 1 1", inpkt2, busy2); end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++; if (inpkt2 !== 1'b0 || mask2 !== 2'b11 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async got inpkt=%b mask=%b busy=%b want 0 11 0", inpkt2, mask2, busy2); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        n_chk++; if (mask2 !== 2'b11 || busy2 !== 1'b0 || appl2 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after got mask=%b busy=%b appl=%b want 11 0 0", mask2, busy2, appl2); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_beat(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step();
        val = 1'b0;
        step();
        n_chk++; if (pc4 !== 4'hF || dc4 !== 4'h0) begin
            n_fail++; $display("FAIL sat_cnt4 got pkt=%0d drop=%0d want 15 0", pc4, dc4); end
        n_chk++; if (pc2 !== 32'd20) begin n_fail++; $display("FAIL sat_cnt2 got %0d want 20", pc2); end
    endtask

    initial begin
        test_reset();
        test_idle_cfg();
        test_mid_pkt();
        test_round_robin();
        test_drop();
        test_double_write();
        test_reset_mid_pkt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
